counter_ctrl: RTL and testbench
===============================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter: DIV, default 4, prescaler divide ratio (ticks every DIV clk cycles while running), legal range >= 2.
REQ-002 Parameter: MAX_VAL, default 4'd15, upper count boundary, legal range 1..15.
REQ-003 Port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: start  input  1  start/resume request, clk-synchronous, rising edge significant.
REQ-006 Port: stop  input  1  pause/abort request, clk-synchronous, rising edge significant.
REQ-007 Port: dir  input  1  direction toggle request, clk-synchronous, rising edge significant.
REQ-008 Port: cnt_val  input  4  current value of the controlled 4-bit up/down counter.
REQ-009 Port: cnt_en  output  1  one-cycle step strobe to the counter.
REQ-010 Port: cnt_up  output  1  counter direction (1 = up, 0 = down).
REQ-011 Port: cnt_clr  output  1  one-cycle counter clear strobe.
REQ-012 Port: state  output  2  FSM state: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10; 2'b11 never produced.
REQ-013 Port: seg  output  7  active-high segments, seg[0]=a … seg[6]=g.
REQ-014 Port: digit  output  1  digit enable, 1 whenever not in reset.

Function
REQ-015 Edge detect: each of start/stop/dir registered once; edge = input & ~input_q, acted on at the same posedge.
REQ-016 IDLE + start edge -> RUN; cnt_clr=1 for the following cycle; prescaler cleared to 0.
REQ-017 RUN + stop edge -> PAUSE; prescaler holds its value.
REQ-018 PAUSE + start edge -> RUN; no cnt_clr; prescaler resumes from held value.
REQ-019 PAUSE + stop edge -> IDLE; cnt_clr=1 for the following cycle.
REQ-020 Simultaneous start and stop edges: stop wins; start ignored.
REQ-021 Dir edge in any state toggles the direction register (cnt_up), effective next cycle.
REQ-022 Prescaler: 0..DIV-1 counter, advances only in RUN; on reaching DIV-1 it wraps to 0 and a tick occurs.
REQ-023 On a RUN tick with no boundary, cnt_en=1 for exactly the next cycle; otherwise cnt_en=0.
REQ-024 Boundary: (cnt_up=1 and cnt_val==MAX_VAL) or (cnt_up=0 and cnt_val==0), evaluated at the tick with registered cnt_up.
REQ-025 Stop edge in the same cycle as a tick: transition to PAUSE wins; no cnt_en issued.
REQ-026 seg: IDLE = 7'b1000000 ("-"); PAUSE = 7'b1110011 ("P"); RUN up = 7'b0111110 ("U"); RUN down = 7'b1011110 ("d").
REQ-027 All outputs registered; cnt_en and cnt_clr never both 1.

Reset
REQ-028 rst=1 at a posedge: state=IDLE, cnt_up=1, cnt_en=0, cnt_clr=0, prescaler=0, edge registers=0, seg=7'b1000000, digit=0.
REQ-029 Reset mid-RUN aborts immediately; no cnt_en or cnt_clr in the cycle after reset; digit=1 from the first cycle after rst deasserts.

Configuration
REQ-030 Macro AUTO_REVERSE_EN defined: on a boundary tick, cnt_up inverts and cnt_en=1 in the same next cycle; e.g. up at MAX_VAL steps down, giving ping-pong counting; state stays RUN.
REQ-031 AUTO_REVERSE_EN undefined: on a boundary tick, cnt_en stays 0 and state -> PAUSE (saturating stop).

Structure
REQ-032 Package counter_ctrl_pkg holds state encodings and the four seg pattern constants.
REQ-033 Prescaler is sub-module tick_gen (ports clk, rst, run, clr, tick; parameter DIV); edge detect and FSM stay in counter_ctrl.

Verification (DIV=4, MAX_VAL=5, external counter model in bench)
REQ-034 Reset, then start pulse -> cnt_clr one cycle, state=01, seg=0111110, cnt_en every 4th cycle, counter reaches 3 after 3 ticks.
REQ-035 Stop in RUN, then start -> PAUSE seg=1110011, no cnt_en while paused, first tick after resume arrives after the remaining prescaler cycles.
REQ-036 Count up to 5: AUTO_REVERSE_EN -> next tick cnt_up=0, counter 4; undefined -> state=10, counter holds 5.
REQ-037 Dir edge at counter 2 while running -> seg=1011110, next tick gives 1; at 0, boundary behaviour mirrors REQ-036.
REQ-038 Start and stop rising in the same cycle from RUN -> PAUSE; from PAUSE -> IDLE with one cnt_clr.
REQ-039 rst asserted mid-RUN between ticks -> all REQ-028 values next cycle; no stray cnt_en after release.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter controller: FSM state encodings
// and seven-segment patterns.
package counter_ctrl_pkg;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  // Active-high segments, bit 0 = a ... bit 6 = g
  localparam logic [SEG_W-1:0] SEG_IDLE  = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_PAUSE = 7'b1110011;
  localparam logic [SEG_W-1:0] SEG_UP    = 7'b0111110;
  localparam logic [SEG_W-1:0] SEG_DOWN  = 7'b1011110;

  function automatic logic [SEG_W-1:0] seg_for(input state_t st, input logic up);
    logic [SEG_W-1:0] pat;
    case (st)
      ST_RUN:   pat = up ? SEG_UP : SEG_DOWN;
      ST_PAUSE: pat = SEG_PAUSE;
      default:  pat = SEG_IDLE;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 while run is high and flags a tick on wrap.
// clr restarts the count from zero; with run low the count is held.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;

  always_ff @(posedge clk) begin
    if (rst) presc <= '0;
    else     presc <= presc_nxt;
  end

  // tick is combinational so the controller can act at the wrapping edge
  always_comb begin
    presc_nxt = presc;
    tick      = 1'b0;
    if (clr) begin
      presc_nxt = '0;
    end else if (run) begin
      if (presc == LAST) begin
        presc_nxt = '0;
        tick      = 1'b1;
      end else begin
        presc_nxt = presc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/idle controller for an external 4-bit up/down counter with a
// prescaled step strobe and a status digit. Optional AUTO_REVERSE_EN macro
// turns the boundary stop into ping-pong counting.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned       DIV     = 4,
  parameter logic [CNT_W-1:0]  MAX_VAL = 4'd15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic [CNT_W-1:0]   cnt_val,
  output logic               cnt_en,
  output logic               cnt_up,
  output logic               cnt_clr,
  output logic [STATE_W-1:0] state,
  output logic [SEG_W-1:0]   seg,
  output logic               digit
);

  logic start_q, stop_q, dir_q;
  logic start_e, stop_e, dir_e;

  state_t           state_r, state_nxt;
  logic             up_r, up_nxt;
  logic             en_nxt, clr_nxt;
  logic [SEG_W-1:0] seg_nxt;

  logic presc_run, presc_clr, tick;
  logic at_bound;

  assign start_e = start & ~start_q;
  assign stop_e  = stop  & ~stop_q;
  assign dir_e   = dir   & ~dir_q;

  // A stop edge freezes the prescaler in the same cycle it leaves RUN
  assign presc_run = (state_r == ST_RUN) && !stop_e;
  assign presc_clr = (state_r == ST_IDLE) && start_e && !stop_e;

  assign at_bound = up_r ? (cnt_val == MAX_VAL) : (cnt_val == '0);

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .run  (presc_run),
    .clr  (presc_clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      dir_q   <= 1'b0;
      state_r <= ST_IDLE;
      up_r    <= 1'b1;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      seg     <= SEG_IDLE;
      digit   <= 1'b0;
    end else begin
      start_q <= start;
      stop_q  <= stop;
      dir_q   <= dir;
      state_r <= state_nxt;
      up_r    <= up_nxt;
      cnt_en  <= en_nxt;
      cnt_clr <= clr_nxt;
      seg     <= seg_nxt;
      digit   <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state_r;
    up_nxt    = up_r ^ dir_e;
    en_nxt    = 1'b0;
    clr_nxt   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start_e && !stop_e) begin
          state_nxt = ST_RUN;
          clr_nxt   = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop_e) begin
          state_nxt = ST_PAUSE;
        end else if (tick) begin
          if (!at_bound) begin
            en_nxt = 1'b1;
          end else begin
`ifdef AUTO_REVERSE_EN
            // Reverse away from the boundary; a coincident dir edge is absorbed
            up_nxt = ~up_r;
            en_nxt = 1'b1;
`else
            state_nxt = ST_PAUSE;
`endif
          end
        end
      end
      ST_PAUSE: begin
        if (stop_e) begin
          state_nxt = ST_IDLE;
          clr_nxt   = 1'b1;
        end else if (start_e) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    seg_nxt = seg_for(state_nxt, up_nxt);
  end

  assign state  = state_r;
  assign cnt_up = up_r;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl (DIV=4, MAX_VAL=5) driving a behavioural
// 4-bit up/down counter from the controller strobes.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] cval = 4'd0;
  logic       cnt_en, cnt_up, cnt_clr, digit;
  logic [1:0] state;
  logic [6:0] seg;

  int n_cmp = 0;
  int n_bad = 0;

  counter_ctrl #(
    .DIV     (4),
    .MAX_VAL (4'd5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .dir     (dir),
    .cnt_val (cval),
    .cnt_en  (cnt_en),
    .cnt_up  (cnt_up),
    .cnt_clr (cnt_clr),
    .state   (state),
    .seg     (seg),
    .digit   (digit)
  );

  always #5 clk = ~clk;

  // External counter driven by the strobes
  always @(posedge clk) begin
    if (cnt_clr)     cval <= 4'd0;
    else if (cnt_en) cval <= cnt_up ? cval + 4'd1 : cval - 4'd1;
  end

  task automatic pulse(input logic s, input logic p, input logic d);
    start = s; stop = p; dir = d;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; dir = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Negedges until cnt_en is seen (20 = expired), then one more negedge
  task automatic wait_en(output int n, output logic en_after, output logic both);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cnt_en !== 1'b1 && n < 20);
    both = cnt_clr;
    @(negedge clk);
    en_after = cnt_en;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL reset_state got %b exp 00", state); end
    n_cmp++; if (cnt_up !== 1'b1) begin n_bad++; $display("FAIL reset_up got %b exp 1", cnt_up); end
    n_cmp++; if (cnt_en !== 1'b0 || cnt_clr !== 1'b0) begin n_bad++; $display("FAIL reset_strobes got en=%b clr=%b exp 0/0", cnt_en, cnt_clr); end
    n_cmp++; if (seg !== 7'b1000000) begin n_bad++; $display("FAIL reset_seg got %b exp 1000000", seg); end
    n_cmp++; if (digit !== 1'b0) begin n_bad++; $display("FAIL reset_digit got %b exp 0", digit); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (digit !== 1'b1) begin n_bad++; $display("FAIL release_digit got %b exp 1", digit); end
  endtask

  task automatic test_start();
    int n; logic ea, bo;
    pulse(1'b1, 1'b0, 1'b0);
    n_cmp++; if (cnt_clr !== 1'b1) begin n_bad++; $display("FAIL start_clr got %b exp 1", cnt_clr); end
    n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL start_state got %b exp 01", state); end
    n_cmp++; if (seg !== 7'b0111110) begin n_bad++; $display("FAIL start_seg got %b exp 0111110", seg); end
    n_cmp++; if (cnt_en !== 1'b0) begin n_bad++; $display("FAIL start_en got %b exp 0", cnt_en); end
    @(negedge clk);
    n_cmp++; if (cnt_clr !== 1'b0) begin n_bad++; $display("FAIL start_clr_len got %b exp 0", cnt_clr); end
    wait_en(n, ea, bo);
    n_cmp++; if (n != 3) begin n_bad++; $display("FAIL first_tick_gap got %0d exp 3", n); end
    n_cmp++; if (ea !== 1'b0 || bo !== 1'b0) begin n_bad++; $display("FAIL first_tick_shape got after=%b clr=%b exp 0/0", ea, bo); end
    for (int i = 0; i < 2; i++) begin
      wait_en(n, ea, bo);
      n_cmp++; if (n != 3) begin n_bad++; $display("FAIL tick_gap%0d got %0d exp 3", i, n); end
    end
    n_cmp++; if (cval !== 4'd3) begin n_bad++; $display("FAIL count_3 got %0d exp 3", cval); end
  endtask

  task automatic test_pause();
    int n; int bad; logic ea, bo;
    pulse(1'b0, 1'b1, 1'b0);
    n_cmp++; if (state !== 2'b10) begin n_bad++; $display("FAIL pause_state got %b exp 10", state); end
    n_cmp++; if (seg !== 7'b1110011) begin n_bad++; $display("FAIL pause_seg got %b exp 1110011", seg); end
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (cnt_en !== 1'b0 || state !== 2'b10) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL pause_hold got %0d bad cycles exp 0", bad); end
    n_cmp++; if (cval !== 4'd3) begin n_bad++; $display("FAIL pause_count got %0d exp 3", cval); end
    pulse(1'b1, 1'b0, 1'b0);
    n_cmp++; if (state !== 2'b01 || cnt_clr !== 1'b0) begin n_bad++; $display("FAIL resume got state=%b clr=%b exp 01/0", state, cnt_clr); end
    wait_en(n, ea, bo);
    n_cmp++; if (n != 3) begin n_bad++; $display("FAIL resume_gap got %0d exp 3", n); end
    n_cmp++; if (cval !== 4'd4) begin n_bad++; $display("FAIL resume_count got %0d exp 4", cval); end
  endtask

  task automatic test_boundary_up();
    int n; logic ea, bo;
    wait_en(n, ea, bo);
    n_cmp++; if (cval !== 4'd5 || n != 3) begin n_bad++; $display("FAIL reach_max got cval=%0d gap=%0d exp 5/3", cval, n); end
    repeat (3) @(negedge clk);
`ifdef AUTO_REVERSE_EN
    n_cmp++; if (cnt_en !== 1'b1 || cnt_up !== 1'b0 || state !== 2'b01) begin n_bad++; $display("FAIL max_reverse got en=%b up=%b st=%b exp 1/0/01", cnt_en, cnt_up, state); end
    n_cmp++; if (seg !== 7'b1011110) begin n_bad++; $display("FAIL max_reverse_seg got %b exp 1011110", seg); end
    @(negedge clk);
    n_cmp++; if (cval !== 4'd4) begin n_bad++; $display("FAIL max_after got %0d exp 4", cval); end
`else
    n_cmp++; if (cnt_en !== 1'b0 || state !== 2'b10) begin n_bad++; $display("FAIL max_sat got en=%b st=%b exp 0/10", cnt_en, state); end
    n_cmp++; if (seg !== 7'b1110011) begin n_bad++; $display("FAIL max_sat_seg got %b exp 1110011", seg); end
    @(negedge clk);
    n_cmp++; if (cval !== 4'd5) begin n_bad++; $display("FAIL max_after got %0d exp 5", cval); end
`endif
  endtask

  task automatic test_dir();
    int n; logic ea, bo;
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    wait_en(n, ea, bo);
    wait_en(n, ea, bo);
    n_cmp++; if (cval !== 4'd2) begin n_bad++; $display("FAIL dir_pre got %0d exp 2", cval); end
    pulse(1'b0, 1'b0, 1'b1);
    n_cmp++; if (cnt_up !== 1'b0 || seg !== 7'b1011110) begin n_bad++; $display("FAIL dir_toggle got up=%b seg=%b exp 0/1011110", cnt_up, seg); end
    wait_en(n, ea, bo);
    n_cmp++; if (n != 2 || cval !== 4'd1) begin n_bad++; $display("FAIL dir_step got gap=%0d cval=%0d exp 2/1", n, cval); end
    wait_en(n, ea, bo);
    n_cmp++; if (cval !== 4'd0) begin n_bad++; $display("FAIL dir_zero got %0d exp 0", cval); end
    repeat (3) @(negedge clk);
`ifdef AUTO_REVERSE_EN
    n_cmp++; if (cnt_en !== 1'b1 || cnt_up !== 1'b1 || state !== 2'b01) begin n_bad++; $display("FAIL zero_reverse got en=%b up=%b st=%b exp 1/1/01", cnt_en, cnt_up, state); end
    @(negedge clk);
    n_cmp++; if (cval !== 4'd1) begin n_bad++; $display("FAIL zero_after got %0d exp 1", cval); end
`else
    n_cmp++; if (cnt_en !== 1'b0 || state !== 2'b10) begin n_bad++; $display("FAIL zero_sat got en=%b st=%b exp 0/10", cnt_en, state); end
    @(negedge clk);
    n_cmp++; if (cval !== 4'd0) begin n_bad++; $display("FAIL zero_after got %0d exp 0", cval); end
`endif
  endtask

  task automatic test_simultaneous();
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    pulse(1'b1, 1'b1, 1'b0);
    n_cmp++; if (state !== 2'b10 || cnt_clr !== 1'b0) begin n_bad++; $display("FAIL both_run got st=%b clr=%b exp 10/0", state, cnt_clr); end
    @(negedge clk);
    pulse(1'b1, 1'b1, 1'b0);
    n_cmp++; if (state !== 2'b00 || cnt_clr !== 1'b1 || cnt_en !== 1'b0) begin n_bad++; $display("FAIL both_pause got st=%b clr=%b en=%b exp 00/1/0", state, cnt_clr, cnt_en); end
    n_cmp++; if (seg !== 7'b1000000) begin n_bad++; $display("FAIL both_pause_seg got %b exp 1000000", seg); end
    @(negedge clk);
    n_cmp++; if (cnt_clr !== 1'b0) begin n_bad++; $display("FAIL both_pause_clr_len got %b exp 0", cnt_clr); end
  endtask

  task automatic test_reset_mid_run();
    int n; int bad; logic ea, bo;
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    wait_en(n, ea, bo);
    pulse(1'b0, 1'b0, 1'b1);
    n_cmp++; if (cnt_up !== 1'b0) begin n_bad++; $display("FAIL mid_dir got %b exp 0", cnt_up); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (state !== 2'b00 || cnt_up !== 1'b1) begin n_bad++; $display("FAIL mid_rst got st=%b up=%b exp 00/1", state, cnt_up); end
    n_cmp++; if (cnt_en !== 1'b0 || cnt_clr !== 1'b0 || digit !== 1'b0) begin n_bad++; $display("FAIL mid_rst_out got en=%b clr=%b dig=%b exp 0/0/0", cnt_en, cnt_clr, digit); end
    n_cmp++; if (seg !== 7'b1000000) begin n_bad++; $display("FAIL mid_rst_seg got %b exp 1000000", seg); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (digit !== 1'b1 || state !== 2'b00) begin n_bad++; $display("FAIL mid_release got dig=%b st=%b exp 1/00", digit, state); end
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (cnt_en !== 1'b0 || cnt_clr !== 1'b0 || state !== 2'b00) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL mid_quiet got %0d bad cycles exp 0", bad); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_pause();
    test_boundary_up();
    test_dir();
    test_simultaneous();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
